can_tx_scheduler: RTL

Upstream feeder for the CAN transmit path. Buffers up to `DEPTH` pending frames, each an 11-bit identifier plus a 64-bit payload. It always issues the lowest-identifier pending frame, matching CAN arbitration priority, onto the `address`/`data`/`send_data` inputs of the bit-stuffing transmit container. It then tracks that container's `txing` output to retire, retry or drop the frame.

---
 rtl/can_pkg.sv | 14 +
 rtl/can_id_prio_select.sv | 30 +++
 rtl/can_tx_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared widths and scheduler state encoding for the CAN transmit scheduler.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE,
    GAP
  } sched_state_t;

endpackage

// File: rtl/can_id_prio_select.sv
// Combinational picker: lowest identifier among valid slots wins, ties go to the lowest slot.
module can_id_prio_select
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]               valid,
  input  logic [DEPTH-1:0][CAN_ID_W-1:0] ids,
  output logic                           any_valid,
  output logic [IDX_W-1:0]               sel_idx
);

  logic [CAN_ID_W-1:0] best_id;

  // Strict less-than keeps the earlier slot when identifiers are equal.
  always_comb begin
    any_valid = 1'b0;
    sel_idx   = '0;
    best_id   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (!any_valid || (ids[i] < best_id))) begin
        any_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        best_id   = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Priority-ordered frame buffer feeding the CAN tx container, with start timeout,
// bounded retry and an enforced inter-frame gap.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 2000,
  parameter int MAX_RETRY     = 3,
  parameter int IFS_CYCLES    = 600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CAN_ID_W-1:0]   wr_addr,
  input  logic [CAN_DATA_W-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  full,
  output logic                  empty,
  output logic [CAN_ID_W-1:0]   address,
  output logic [CAN_DATA_W-1:0] data,
  output logic                  send_data,
  input  logic                  txing,
  output logic                  tx_done,
  output logic                  tx_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFS_CYCLES + 1);

  sched_state_t state;

  logic [DEPTH-1:0]                 valid;
  logic [DEPTH-1:0]                 valid_next;
  logic [DEPTH-1:0][CAN_ID_W-1:0]   slot_id;
  logic [DEPTH-1:0][CAN_DATA_W-1:0] slot_payload;
  logic [DEPTH-1:0][RTY_W-1:0]      slot_retries;

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             any_valid;
  logic             wr_accept;

  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             txing_q;

  logic timed_out;
  logic retry_exhausted;
  logic frame_done;
  logic frame_drop;

  can_id_prio_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .valid     (valid),
    .ids       (slot_id),
    .any_valid (any_valid),
    .sel_idx   (sel_idx)
  );

  // Lowest-index free slot; only meaningful when the queue is not full.
  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) wr_idx = IDX_W'(i);
    end
  end

  assign wr_accept       = wr_en && !(&valid);
  assign timed_out       = (state == ISSUE) && !txing && (tmo_cnt == TMO_W'(START_TIMEOUT));
  assign retry_exhausted = (slot_retries[cur_idx] == RTY_W'(MAX_RETRY));
  assign frame_done      = (state == ACTIVE) && txing_q && !txing;
  assign frame_drop      = timed_out && retry_exhausted;

  // The written slot is always free and the retired slot always valid, so they never collide.
  always_comb begin
    valid_next = valid;
    if (wr_accept) valid_next[wr_idx] = 1'b1;
    if (frame_done || frame_drop) valid_next[cur_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      slot_id[wr_idx]      <= wr_addr;
      slot_payload[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      slot_retries <= '0;
      cur_idx      <= '0;
      address      <= '0;
      data         <= '0;
      send_data    <= 1'b0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      txing_q      <= 1'b0;
      wr_ack       <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      valid   <= valid_next;
      full    <= &valid_next;
      empty   <= ~|valid_next;
      txing_q <= txing;
      wr_ack  <= wr_accept;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (wr_accept) slot_retries[wr_idx] <= '0;

      case (state)
        IDLE: begin
          if (any_valid) begin
            cur_idx <= sel_idx;
            address <= slot_id[sel_idx];
            data    <= slot_payload[sel_idx];
            tmo_cnt <= '0;
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          if (txing) begin
            send_data <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ACTIVE;
          end else if (timed_out) begin
            send_data <= 1'b0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
            if (retry_exhausted) begin
              tx_err <= 1'b1;
            end else begin
              slot_retries[cur_idx] <= slot_retries[cur_idx] + RTY_W'(1);
            end
          end else begin
            send_data <= 1'b1;
            tmo_cnt   <= tmo_cnt + TMO_W'(1);
          end
        end

        ACTIVE: begin
          if (frame_done) begin
            tx_done <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(IFS_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
